// File: rtl/regfile_write_arbiter_if.sv
// Writeback/multi-cycle-result bus of the GPR write-port arbiter.
// Macro REGFILE_ARB_STATS_EN adds the defer_count_out statistics signal.
interface regfile_write_arbiter_if;
  logic        wb_enable;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_idx;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        write_enable;
  logic [4:0]  write_idx;
  logic [31:0] write_data;
  logic        buffer_full_out;
`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] defer_count_out;

  modport master (
    output wb_enable, wb_idx, wb_data, mdu_valid, mdu_idx, mdu_data,
    input  mdu_ready, write_enable, write_idx, write_data, buffer_full_out,
    input  defer_count_out
  );
  modport slave (
    input  wb_enable, wb_idx, wb_data, mdu_valid, mdu_idx, mdu_data,
    output mdu_ready, write_enable, write_idx, write_data, buffer_full_out,
    output defer_count_out
  );
`else
  modport master (
    output wb_enable, wb_idx, wb_data, mdu_valid, mdu_idx, mdu_data,
    input  mdu_ready, write_enable, write_idx, write_data, buffer_full_out
  );
  modport slave (
    input  wb_enable, wb_idx, wb_data, mdu_valid, mdu_idx, mdu_data,
    output mdu_ready, write_enable, write_idx, write_data, buffer_full_out
  );
`endif
endinterface

// File: rtl/regfile_write_arbiter.sv
// Single GPR write port shared by pipeline writeback and a 2-deep buffer of mul/div results.
// Macro REGFILE_ARB_STATS_EN adds a saturating count of cycles the buffer was deferred.
module regfile_write_arbiter (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;

  occ_t        state_r;
  occ_t        state_s;
  logic [4:0]  idx0_r, idx1_r, idx0_s, idx1_s;
  logic [31:0] data0_r, data1_r, data0_s, data1_s;
  logic        write_enable_r;
  logic [4:0]  write_idx_r;
  logic [31:0] write_data_r;
  logic        wb_take_s, mdu_live_s, has0_s, has1_s, keep0_s, keep1_s;
  logic        pop_s, bypass_s, push_s, sel_en_s;
  logic [4:0]  sel_idx_s;
  logic [31:0] sel_data_s;
  logic [1:0]  cnt_s;

  // Port grant by priority and next buffer contents (invalidate, pop, compact, push)
  always_comb begin
    wb_take_s  = bus.wb_enable && (bus.wb_idx != 5'd0);
    mdu_live_s = bus.mdu_valid && (state_r != FULL) && (bus.mdu_idx != 5'd0);
    has0_s     = (state_r != EMPTY);
    has1_s     = (state_r == FULL);
    // A same-cycle pipeline write to the same register supersedes the older buffered result
    keep0_s    = has0_s && !(wb_take_s && (idx0_r == bus.wb_idx));
    keep1_s    = has1_s && !(wb_take_s && (idx1_r == bus.wb_idx));
    pop_s      = !wb_take_s && has0_s;
    bypass_s   = !wb_take_s && !has0_s && mdu_live_s;
    push_s     = mdu_live_s && !bypass_s;

    sel_en_s   = 1'b0;
    sel_idx_s  = 5'd0;
    sel_data_s = 32'd0;
    if (wb_take_s) begin
      sel_en_s   = 1'b1;
      sel_idx_s  = bus.wb_idx;
      sel_data_s = bus.wb_data;
    end else if (pop_s) begin
      sel_en_s   = 1'b1;
      sel_idx_s  = idx0_r;
      sel_data_s = data0_r;
    end else if (bypass_s) begin
      sel_en_s   = 1'b1;
      sel_idx_s  = bus.mdu_idx;
      sel_data_s = bus.mdu_data;
    end else begin
      sel_en_s   = 1'b0;
    end

    idx0_s  = idx0_r;
    data0_s = data0_r;
    idx1_s  = idx1_r;
    data1_s = data1_r;
    cnt_s   = 2'd0;
    if (keep0_s && !pop_s) begin
      cnt_s = 2'd1;
      if (keep1_s) begin
        cnt_s = 2'd2;
      end else begin
        cnt_s = 2'd1;
      end
    end else if (keep1_s) begin
      idx0_s  = idx1_r;
      data0_s = data1_r;
      cnt_s   = 2'd1;
    end else begin
      cnt_s = 2'd0;
    end

    if (push_s) begin
      if (cnt_s == 2'd0) begin
        idx0_s  = bus.mdu_idx;
        data0_s = bus.mdu_data;
      end else begin
        idx1_s  = bus.mdu_idx;
        data1_s = bus.mdu_data;
      end
      cnt_s = cnt_s + 2'd1;
    end else begin
      cnt_s = cnt_s;
    end

    case (cnt_s)
      2'd0:    state_s = EMPTY;
      2'd1:    state_s = ONE;
      2'd2:    state_s = FULL;
      default: state_s = EMPTY;
    endcase
  end

  // Buffer state and registered write port; index/data hold while the port is idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= EMPTY;
      idx0_r         <= 5'd0;
      idx1_r         <= 5'd0;
      data0_r        <= 32'd0;
      data1_r        <= 32'd0;
      write_enable_r <= 1'b0;
      write_idx_r    <= 5'd0;
      write_data_r   <= 32'd0;
    end else begin
      state_r        <= state_s;
      idx0_r         <= idx0_s;
      idx1_r         <= idx1_s;
      data0_r        <= data0_s;
      data1_r        <= data1_s;
      write_enable_r <= sel_en_s;
      if (sel_en_s) begin
        write_idx_r  <= sel_idx_s;
        write_data_r <= sel_data_s;
      end
    end
  end

  assign bus.mdu_ready       = (state_r != FULL);
  assign bus.buffer_full_out = (state_r == FULL);
  assign bus.write_enable    = write_enable_r;
  assign bus.write_idx       = write_idx_r;
  assign bus.write_data      = write_data_r;

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] defer_count_r;

  // Saturating count of cycles the buffer held data but lost the port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      defer_count_r <= 16'd0;
    end else if (has0_s && !pop_s && (defer_count_r != 16'hFFFF)) begin
      defer_count_r <= defer_count_r + 16'd1;
    end
  end

  assign bus.defer_count_out = defer_count_r;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;
  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  ent_t        model_q[$];
  logic        exp_we;
  logic [4:0]  exp_idx;
  logic [31:0] exp_data;
  int          exp_defer;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic reset_model();
    model_q.delete();
    exp_we    = 1'b0;
    exp_idx   = 5'd0;
    exp_data  = 32'd0;
    exp_defer = 0;
  endtask

  // One clock: check outputs at the falling edge, then drive inputs and advance the model.
  task automatic cycle(input logic en, input logic [4:0] wi, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mi, input logic [31:0] md);
    logic acc;
    logic bypassed;
    ent_t e;
    @(negedge clk);
    check_value("write_enable", {31'd0, bus.write_enable}, {31'd0, exp_we});
    check_value("write_idx", {27'd0, bus.write_idx}, {27'd0, exp_idx});
    check_value("write_data", bus.write_data, exp_data);
    check_value("mdu_ready", {31'd0, bus.mdu_ready}, (model_q.size() < 2) ? 32'd1 : 32'd0);
    check_value("buffer_full", {31'd0, bus.buffer_full_out}, (model_q.size() == 2) ? 32'd1 : 32'd0);
`ifdef REGFILE_ARB_STATS_EN
    check_value("defer_count", {16'd0, bus.defer_count_out}, exp_defer);
`endif
    bus.wb_enable = en;
    bus.wb_idx    = wi;
    bus.wb_data   = wd;
    bus.mdu_valid = mv;
    bus.mdu_idx   = mi;
    bus.mdu_data  = md;

    acc      = mv && (model_q.size() < 2);
    bypassed = 1'b0;
    if (en && wi != 5'd0) begin
      if (model_q.size() > 0 && exp_defer < 65535) exp_defer++;
      for (int i = model_q.size() - 1; i >= 0; i--) begin
        if (model_q[i].idx == wi) model_q.delete(i);
      end
      exp_we = 1'b1; exp_idx = wi; exp_data = wd;
    end else if (model_q.size() > 0) begin
      e = model_q.pop_front();
      exp_we = 1'b1; exp_idx = e.idx; exp_data = e.data;
    end else if (acc && mi != 5'd0) begin
      exp_we = 1'b1; exp_idx = mi; exp_data = md;
      bypassed = 1'b1;
    end else begin
      exp_we = 1'b0;
    end
    if (acc && mi != 5'd0 && !bypassed) model_q.push_back('{idx: mi, data: md});
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Shortly after the next rising edge, compare the write port against fixed values.
  task automatic peek_write(input string tag, input logic [4:0] idx, input logic [31:0] data);
    #6;
    check_value({tag, "_en"}, {31'd0, bus.write_enable}, 32'd1);
    check_value({tag, "_idx"}, {27'd0, bus.write_idx}, {27'd0, idx});
    check_value({tag, "_data"}, bus.write_data, data);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_model();
    bus.wb_enable = 1'b0; bus.wb_idx = 5'd0; bus.wb_data = 32'd0;
    bus.mdu_valid = 1'b0; bus.mdu_idx = 5'd0; bus.mdu_data = 32'd0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    idle();
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    peek_write("wb_basic", 5'd5, 32'hDEADBEEF);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12);
    peek_write("bypass", 5'd7, 32'h12);
    check_value("bypass_empty", {31'd0, bus.buffer_full_out}, 32'd0);
    idle();

    // Fill the buffer behind three pipeline writes.
    cycle(1'b1, 5'd1, 32'h101, 1'b1, 5'd8, 32'h808);
    cycle(1'b1, 5'd2, 32'h202, 1'b1, 5'd9, 32'h909);
    cycle(1'b1, 5'd3, 32'h303, 1'b1, 5'd11, 32'hB0B);
    check_value("full_ready", {31'd0, bus.mdu_ready}, 32'd0);
    check_value("full_flag", {31'd0, bus.buffer_full_out}, 32'd1);
    idle();
    peek_write("drain8", 5'd8, 32'h808);
    idle();
    peek_write("drain9", 5'd9, 32'h909);
    idle();

    // Pipeline write supersedes a buffered result to the same register.
    cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hAA);
    cycle(1'b1, 5'd10, 32'hBB, 1'b0, 5'd0, 32'd0);
    peek_write("supersede", 5'd10, 32'hBB);
    check_value("supersede_empty", {31'd0, bus.mdu_ready}, 32'd1);
    idle();
    idle();

    // Writeback to x0 does not block the buffer head.
    cycle(1'b1, 5'd2, 32'h2, 1'b1, 5'd4, 32'h44);
    cycle(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
    peek_write("x0_head", 5'd4, 32'h44);
    idle();

    // Reset in the middle of a cycle with a full buffer.
    cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC);
    cycle(1'b1, 5'd2, 32'h2, 1'b1, 5'd13, 32'hD);
    cycle(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_value("rst_we", {31'd0, bus.write_enable}, 32'd0);
    check_value("rst_ready", {31'd0, bus.mdu_ready}, 32'd1);
    check_value("rst_full", {31'd0, bus.buffer_full_out}, 32'd0);
    bus.wb_enable = 1'b0; bus.mdu_valid = 1'b0;
    reset_model();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) idle();

    for (int n = 0; n < 2000; n++) begin
      cycle(($urandom_range(0, 1) == 1), 5'($urandom_range(0, (n < 1000) ? 7 : 31)), $urandom,
            ($urandom_range(0, 2) != 0), 5'($urandom_range(0, (n < 1000) ? 7 : 31)), $urandom);
    end
    repeat (3) idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-high reset.
REQ-002 SHALL have port wb_enable  in  1  pipeline writeback request (never back-pressured).
REQ-003 SHALL have port wb_idx  in  5  pipeline writeback destination register.
REQ-004 SHALL have port wb_data  in  32  pipeline writeback value.
REQ-005 SHALL have port mdu_valid  in  1  multi-cycle unit (mul/div) result valid.
REQ-006 SHALL have port mdu_idx  in  5  multi-cycle result destination register.
REQ-007 SHALL have port mdu_data  in  32  multi-cycle result value.
REQ-008 SHALL have port mdu_ready  out  1  arbiter can accept a multi-cycle result this cycle.
REQ-009 SHALL have port write_enable  out  1  registered GPR write-port enable.
REQ-010 SHALL have port write_idx  out  5  registered GPR write-port index.
REQ-011 SHALL have port write_data  out  32  registered GPR write-port data.
REQ-012 SHALL have port buffer_full_out  out  1  both buffer entries occupied (decode stalls issue of new multi-cycle ops).

Function
REQ-013 SHALL hold a 2-entry in-order FIFO of multi-cycle results (index, data); occupancy states EMPTY, ONE, FULL.
REQ-014 SHALL drive mdu_ready = 1 in EMPTY and ONE, 0 in FULL, independent of any same-cycle pop.
REQ-015 SHALL accept a multi-cycle result on a cycle with mdu_valid && mdu_ready.
REQ-016 SHALL select each cycle, priority: (1) wb_enable with wb_idx != 0; (2) FIFO head; (3) accepted multi-cycle result in the same cycle (bypass, not enqueued).
REQ-017 SHALL register the selected write onto write_enable/write_idx/write_data at the next rising edge (latency exactly 1 cycle); write_enable = 0 when nothing selected.
REQ-018 SHALL enqueue an accepted multi-cycle result not granted in its cycle; simultaneous pop and push in ONE stays ONE with order preserved.
REQ-019 SHALL discard any write with index 0: a wb to x0 does not take the port; an accepted mdu result to x0 is neither written nor enqueued.
REQ-020 SHALL invalidate any buffered entry whose index equals an accepted wb_idx the same cycle (the pipeline write is younger); invalidated entries are removed without taking the port, compacting the FIFO.
REQ-021 SHALL hold write_data/write_idx at their previous values when write_enable = 0.
REQ-022 SHALL assert buffer_full_out combinationally from the FULL state.

Reset
REQ-023 SHALL on reset, asynchronously: FIFO to EMPTY, write_enable = 0, write_idx = 0, write_data = 0, all entries invalid.
REQ-024 SHALL discard buffered results on reset mid-operation; mdu_ready = 1 and buffer_full_out = 0 while reset is high.

Configuration
REQ-025 SHALL, with macro REGFILE_ARB_STATS_EN defined, add output defer_count_out (out, 16) counting cycles with a non-empty FIFO not granted the port, saturating at 0xFFFF, reset to 0.
REQ-026 SHALL, without REGFILE_ARB_STATS_EN, omit defer_count_out and its counter; all other behaviour identical.

Verification
REQ-027 SHALL cover: wb_enable=1, wb_idx=5, wb_data=0xDEADBEEF, mdu_valid=0 -> next cycle write_enable=1, write_idx=5, write_data=0xDEADBEEF.
REQ-028 SHALL cover: mdu_valid=1, mdu_idx=7, mdu_data=0x12, wb idle -> bypass, next cycle write idx 7 data 0x12, FIFO stays EMPTY.
REQ-029 SHALL cover: wb active 3 cycles (idx 1,2,3) while mdu offers idx 8 then 9 -> FIFO FULL, mdu_ready=0 and buffer_full_out=1 on cycle 3; writes 1,2,3,8,9 in that order.
REQ-030 SHALL cover: buffered entry idx 10 data 0xAA, then wb idx 10 data 0xBB -> only 0xBB written to reg 10, FIFO EMPTY afterwards.
REQ-031 SHALL cover: wb_idx=0 with wb_enable=1 and FIFO holding idx 4 -> FIFO head idx 4 granted, no write to x0.
REQ-032 SHALL cover: reset asserted mid-cycle with FIFO FULL -> immediately write_enable=0, mdu_ready=1, buffer_full_out=0; no buffered write after release.
